music_scheduler: RTL and testbench
==================================

Name: music_scheduler

Overview:
- Central sound controller for the game.
- Sequences the background-tune players (start, in-game and game-over) from the current game state, and inserts a muted gap between tunes so each player's note counter restarts.
- Arbitrates one-shot sound-effect requests onto the single audio pin. Sound effects pre-empt background music.
- Sits between the game FSM and the tune/SFX generator modules, and drives the board's audio output.

Parameters:
- TICK_DIV, 500000: clk cycles per scheduler tick (10 ms at 50 MHz).
- GAP_TICKS, 20: ticks of forced silence between background tunes.
- SFX_TICKS, 30: duration of one sound effect, in ticks.
- NUM_SFX, 4: number of sound-effect requesters/generators.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous reset, active-high
- game_state  in  2  0=start screen, 1=playing, 2=game over, 3=paused
- sfx_req  in  NUM_SFX  one-cycle request pulses, one per effect
- audio_start  in  1  square wave from start-tune player
- audio_game  in  1  square wave from in-game tune player
- audio_over  in  1  square wave from game-over tune player
- audio_sfx  in  NUM_SFX  square waves from effect generators
- enable_startmusic  out  1  run enable, start-tune player
- enable_gamemusic  out  1  run enable, in-game player
- enable_overmusic  out  1  run enable, game-over player
- enable_sfx  out  NUM_SFX  one-hot run enable, effect generators
- audio  out  1  registered mixed output to speaker
- sfx_busy  out  1  an effect is currently granted

Behaviour:
- Reset (rst=1 at a clk edge) clears everything:
  - All outputs go to 0; tick counter, pending mask and SFX counter go to 0.
  - The latched state becomes 0. The FSM goes to GAP with gap count 0.
  - Result: the start tune begins GAP_TICKS ticks after reset release.
- Tick generation:
  - Counter runs 0..TICK_DIV-1, free-running and never paused.
  - tick=1 for one cycle when the count equals TICK_DIV-1, then the counter wraps to 0.
- Background FSM states and transitions:
  - States: GAP, BGM, MUTE.
  - game_state is compared every cycle against the latched state. On a mismatch: latch the new value, drop all three BGM enables on the next edge, then enter MUTE if the new value is 3, otherwise GAP with gap count 0.
  - GAP: all BGM enables 0. Gap count increments on each tick. When a tick arrives with count = GAP_TICKS-1, go to BGM on that edge.
  - BGM: exactly one enable is high, selected by the latched state (0 start, 1 game, 2 over). It holds until the next state change.
  - MUTE (paused): all enables 0; audio=0.
  - A state change during GAP restarts the gap from 0 with the new state.
  - Leaving MUTE goes through a full GAP.
- Sound-effect arbitration:
  - Pending mask: pending |= sfx_req every cycle, except in MUTE.
  - Grant condition: no effect active, pending nonzero, FSM not MUTE. The lowest-index pending bit wins (fixed priority).
  - On grant: that pending bit clears, enable_sfx[i]=1, sfx_busy=1, SFX tick count = 0.
  - Release: the effect ends on the tick where count = SFX_TICKS-1. enable_sfx and sfx_busy drop on that edge.
  - The next grant is no earlier than 1 cycle after release, so the generator sees enable low at least one cycle.
  - A request arriving on the grant cycle for the same index stays pending and replays later. A running effect is never restarted.
  - A game_state change does not disturb a running effect.
  - Entering MUTE aborts any running effect and clears pending on the same edge.
- Audio mux, registered with 1-cycle latency:
  - sfx_busy: audio <= audio_sfx[granted index].
  - Otherwise in BGM: audio <= the selected tune's input.
  - Otherwise (GAP, MUTE): audio <= 0.
- Unselected generator inputs are ignored. Inputs are synchronous to clk; no synchronisers are required.

Decomposition:
- music_pkg holds:
  - game-state encodings ST_START, ST_PLAY, ST_OVER, ST_PAUSE;
  - FSM state encodings GAP, BGM, MUTE;
  - the default TICK_DIV, GAP_TICKS and SFX_TICKS values.
- The tune players also use music_pkg, for shared note codes.
- One natural sub-module, music_tick_gen: the TICK_DIV prescaler emitting a one-cycle tick. It is reused by the tune players in place of their local dividers.

Test Plan (bench params TICK_DIV=4, GAP_TICKS=2, SFX_TICKS=3, NUM_SFX=4):
- Release rst with game_state=0 -> enable_startmusic rises on the edge after the 2nd tick; audio follows audio_start 1 cycle later; the other enables stay 0.
- In BGM start, set game_state=1 -> enable_startmusic falls next edge; audio=0 for the gap; enable_gamemusic rises after 2 ticks.
- Pulse sfx_req=4'b0110 in one cycle -> enable_sfx=0010 for 3 ticks, then ≥1 cycle low, then 0100 for 3 ticks; audio tracks audio_sfx[1] then audio_sfx[2]; the BGM enable stays high throughout.
- Pulse sfx_req[0] during a running effect 0 -> the effect is not restarted; effect 0 replays after release plus 1 cycle.
- During effect 3, set game_state=3 -> enable_sfx=0, sfx_busy=0, all BGM enables 0 next edge; audio=0; sfx_req pulses while paused are discarded (no grant after unpause).
- Assert rst mid-effect and mid-BGM -> all outputs 0 on the next edge; pending is cleared; the start tune restarts after 2 ticks.

Source files
------------

// File: rtl/music_pkg.sv
// Shared definitions for the sound subsystem: the game-state and
// background-FSM encodings, the default timing constants, the note codes
// used by the tune players, and a helper that maps a game state to a
// background-tune enable.
package music_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_PLAY  = 2'd1,
    ST_OVER  = 2'd2,
    ST_PAUSE = 2'd3
  } game_state_t;

  typedef enum logic [1:0] {
    GAP  = 2'd0,
    BGM  = 2'd1,
    MUTE = 2'd2
  } bgm_state_t;

  localparam int unsigned DEF_TICK_DIV  = 500000;  // 10 ms at 50 MHz
  localparam int unsigned DEF_GAP_TICKS = 20;
  localparam int unsigned DEF_SFX_TICKS = 30;

  // Note codes shared by the tune players' note tables.
  typedef enum logic [3:0] {
    NOTE_REST = 4'd0,
    NOTE_C4   = 4'd1,
    NOTE_D4   = 4'd2,
    NOTE_E4   = 4'd3,
    NOTE_F4   = 4'd4,
    NOTE_G4   = 4'd5,
    NOTE_A4   = 4'd6,
    NOTE_B4   = 4'd7,
    NOTE_C5   = 4'd8
  } note_t;

  // Enable vector {over, game, start} for the tune matching a game state.
  function automatic logic [2:0] bgm_select(input game_state_t gs);
    case (gs)
      ST_START: return 3'b001;
      ST_PLAY:  return 3'b010;
      ST_OVER:  return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/music_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset (counter to 0)
//   tick - high for one cycle when the count reaches TICK_DIV-1
module music_tick_gen
  import music_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/music_scheduler.sv
// Central sound controller. Sequences the background tunes from the game
// state with a silent gap between tunes, and arbitrates one-shot sound
// effects (fixed priority, lowest index first) that pre-empt the music.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   game_state         - 0 start, 1 playing, 2 game over, 3 paused
//   sfx_req            - one-cycle request pulse per effect
//   audio_start/game/over, audio_sfx - square waves from the generators
//   enable_startmusic/gamemusic/overmusic - background tune run enables
//   enable_sfx         - one-hot run enable for the granted effect
//   audio              - registered speaker output
//   sfx_busy           - an effect currently holds the output
module music_scheduler
  import music_pkg::*;
#(
  parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
  parameter int unsigned GAP_TICKS = DEF_GAP_TICKS,
  parameter int unsigned SFX_TICKS = DEF_SFX_TICKS,
  parameter int unsigned NUM_SFX   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         game_state,
  input  logic [NUM_SFX-1:0] sfx_req,
  input  logic               audio_start,
  input  logic               audio_game,
  input  logic               audio_over,
  input  logic [NUM_SFX-1:0] audio_sfx,
  output logic               enable_startmusic,
  output logic               enable_gamemusic,
  output logic               enable_overmusic,
  output logic [NUM_SFX-1:0] enable_sfx,
  output logic               audio,
  output logic               sfx_busy
);

  localparam int unsigned GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int unsigned SW = (SFX_TICKS > 1) ? $clog2(SFX_TICKS) : 1;
  localparam int unsigned IW = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1;

  logic tick;

  music_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // ---------------------------------------------------------------------
  // Background FSM
  // ---------------------------------------------------------------------
  bgm_state_t    state, state_next;
  game_state_t   gs_q;
  logic [GW-1:0] gap_cnt, gap_cnt_next;
  logic          gs_change;
  logic          enter_mute;
  logic [2:0]    bgm_en;

  assign gs_change  = (game_state != gs_q);
  assign enter_mute = gs_change && (game_state == ST_PAUSE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= GAP;
      gs_q    <= ST_START;
      gap_cnt <= '0;
    end else begin
      state   <= state_next;
      gap_cnt <= gap_cnt_next;
      if (gs_change) begin
        gs_q <= game_state_t'(game_state);
      end
    end
  end

  // A state change overrides everything, including a coincident tick, so
  // the new tune always gets a full gap.
  always_comb begin
    state_next   = state;
    gap_cnt_next = gap_cnt;
    if (gs_change) begin
      state_next   = enter_mute ? MUTE : GAP;
      gap_cnt_next = '0;
    end else begin
      case (state)
        GAP: begin
          if (tick) begin
            if (gap_cnt == GW'(GAP_TICKS - 1)) begin
              state_next   = BGM;
              gap_cnt_next = '0;
            end else begin
              gap_cnt_next = gap_cnt + GW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bgm_en = '0;
    if (state == BGM) begin
      bgm_en = bgm_select(gs_q);
    end
  end

  assign enable_startmusic = bgm_en[0];
  assign enable_gamemusic  = bgm_en[1];
  assign enable_overmusic  = bgm_en[2];

  // ---------------------------------------------------------------------
  // Sound-effect arbitration
  // ---------------------------------------------------------------------
  logic [NUM_SFX-1:0] pending;
  logic               sfx_active;
  logic [IW-1:0]      sfx_idx;
  logic [SW-1:0]      sfx_cnt;
  logic               grant;
  logic [IW-1:0]      grant_idx;
  logic [NUM_SFX-1:0] grant_mask;
  logic               found;

  always_comb begin
    grant_idx  = '0;
    grant_mask = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < NUM_SFX; i++) begin
      if (pending[i] && !found) begin
        grant_idx     = IW'(i);
        grant_mask[i] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  // Grant only from an idle arbiter: the release edge clears sfx_active,
  // so the generator always sees its enable low for at least one cycle.
  assign grant = !sfx_active && (pending != '0) && (state != MUTE);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= '0;
      sfx_active <= 1'b0;
      sfx_idx    <= '0;
      sfx_cnt    <= '0;
    end else if (enter_mute) begin
      pending    <= '0;
      sfx_active <= 1'b0;
      sfx_cnt    <= '0;
    end else begin
      // The granted bit is cleared from the old mask before OR-ing in this
      // cycle's requests, so a same-index request on the grant cycle replays.
      if (state == MUTE) begin
        pending <= '0;
      end else begin
        pending <= (pending & ~({NUM_SFX{grant}} & grant_mask)) | sfx_req;
      end
      if (grant) begin
        sfx_active <= 1'b1;
        sfx_idx    <= grant_idx;
        sfx_cnt    <= '0;
      end else if (sfx_active && tick) begin
        if (sfx_cnt == SW'(SFX_TICKS - 1)) begin
          sfx_active <= 1'b0;
        end else begin
          sfx_cnt <= sfx_cnt + SW'(1);
        end
      end
    end
  end

  always_comb begin
    enable_sfx = '0;
    if (sfx_active) begin
      enable_sfx[sfx_idx] = 1'b1;
    end
  end

  assign sfx_busy = sfx_active;

  // ---------------------------------------------------------------------
  // Output mux
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      audio <= 1'b0;
    end else if (sfx_active) begin
      audio <= audio_sfx[sfx_idx];
    end else if (state == BGM) begin
      case (gs_q)
        ST_START: audio <= audio_start;
        ST_PLAY:  audio <= audio_game;
        ST_OVER:  audio <= audio_over;
        default:  audio <= 1'b0;
      endcase
    end else begin
      audio <= 1'b0;
    end
  end

endmodule

// File: tb/tb_music_scheduler.sv
// Directed bench for music_scheduler with TICK_DIV=4, GAP_TICKS=2,
// SFX_TICKS=3, NUM_SFX=4. Edges are numbered from the last reset edge (E0);
// ticks are sampled on edges E4, E8, E12, ...
module tb_music_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] game_state;
  logic [3:0] sfx_req;
  logic       audio_start, audio_game, audio_over;
  logic [3:0] audio_sfx;
  logic       enable_startmusic, enable_gamemusic, enable_overmusic;
  logic [3:0] enable_sfx;
  logic       audio, sfx_busy;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int base      = 0;

  music_scheduler #(
    .TICK_DIV  (4),
    .GAP_TICKS (2),
    .SFX_TICKS (3),
    .NUM_SFX   (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .game_state        (game_state),
    .sfx_req           (sfx_req),
    .audio_start       (audio_start),
    .audio_game        (audio_game),
    .audio_over        (audio_over),
    .audio_sfx         (audio_sfx),
    .enable_startmusic (enable_startmusic),
    .enable_gamemusic  (enable_gamemusic),
    .enable_overmusic  (enable_overmusic),
    .enable_sfx        (enable_sfx),
    .audio             (audio),
    .sfx_busy          (sfx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #20000;
    $display("FAIL watchdog: observed no finish, expected finish before 20000 ns");
    $fatal(1, "watchdog expired");
  end

  // Advance to 1 time unit after edge E<k> (relative to the last reset).
  task automatic goto(input int k);
    while (cyc < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bgm(input string tag, input logic [2:0] exp);
    check(tag, {29'd0, enable_overmusic, enable_gamemusic, enable_startmusic}, {29'd0, exp});
  endtask

  initial begin
    rst         = 1'b1;
    game_state  = 2'd0;
    sfx_req     = 4'b0000;
    audio_start = 1'b1;
    audio_game  = 1'b0;
    audio_over  = 1'b1;
    audio_sfx   = 4'b1111;
    @(posedge clk);
    #1;
    base = cyc;   // E0: reset edge
    rst  = 1'b0;
    check_bgm("reset_bgm", 3'b000);
    check("reset_sfx", enable_sfx, 4'b0000);
    check("reset_busy", sfx_busy, 1'b0);
    check("reset_audio", audio, 1'b0);

    // Start tune after two ticks
    goto(5);
    check("gap_audio_silent", audio, 1'b0);
    goto(7);
    check_bgm("start_before", 3'b000);
    goto(8);
    check_bgm("start_rise", 3'b001);
    check("start_audio_lag", audio, 1'b0);
    goto(9);
    check("start_audio_follow", audio, 1'b1);
    audio_start = 1'b0;
    goto(10);
    check("start_audio_low", audio, 1'b0);

    // Switch to the in-game tune
    game_state  = 2'd1;
    audio_start = 1'b1;
    audio_game  = 1'b1;
    goto(11);
    check_bgm("play_start_drop", 3'b000);
    goto(13);
    check("play_gap_audio", audio, 1'b0);
    goto(15);
    check_bgm("play_gap_hold", 3'b000);
    goto(16);
    check_bgm("play_rise", 3'b010);
    goto(17);
    check("play_audio", audio, 1'b1);

    // Two requests in one cycle: index 1 first, then index 2
    sfx_req = 4'b0110;
    goto(18);
    sfx_req   = 4'b0000;
    audio_sfx = 4'b0010;
    goto(19);
    check("sfx1_grant", enable_sfx, 4'b0010);
    check("sfx1_busy", sfx_busy, 1'b1);
    check_bgm("sfx1_bgm_kept", 3'b010);
    goto(20);
    check("sfx1_audio_hi", audio, 1'b1);
    audio_sfx = 4'b1101;
    goto(21);
    check("sfx1_audio_lo", audio, 1'b0);
    goto(27);
    check("sfx1_hold", enable_sfx, 4'b0010);
    audio_sfx = 4'b1011;
    goto(28);
    check("sfx1_release", enable_sfx, 4'b0000);
    check("sfx1_release_busy", sfx_busy, 1'b0);
    check_bgm("sfx_gap_bgm", 3'b010);
    goto(29);
    check("sfx2_grant", enable_sfx, 4'b0100);
    check("sfx_gap_audio_bgm", audio, 1'b1);
    goto(30);
    check("sfx2_audio", audio, 1'b0);
    goto(39);
    check("sfx2_hold", enable_sfx, 4'b0100);
    goto(40);
    check("sfx2_release", enable_sfx, 4'b0000);

    // Re-request during a running effect: no restart, replay afterwards
    sfx_req = 4'b0001;
    goto(41);
    sfx_req = 4'b0000;
    goto(42);
    check("sfx0_grant", enable_sfx, 4'b0001);
    goto(44);
    sfx_req = 4'b0001;
    goto(45);
    sfx_req = 4'b0000;
    goto(51);
    check("sfx0_no_restart", enable_sfx, 4'b0001);
    goto(52);
    check("sfx0_release", enable_sfx, 4'b0000);
    check("sfx0_release_busy", sfx_busy, 1'b0);
    goto(53);
    check("sfx0_replay", enable_sfx, 4'b0001);
    goto(63);
    check("sfx0_replay_hold", enable_sfx, 4'b0001);
    goto(64);
    check("sfx0_replay_end", enable_sfx, 4'b0000);

    // Pause during effect 3
    sfx_req = 4'b1000;
    goto(65);
    sfx_req   = 4'b0000;
    audio_sfx = 4'b1000;
    goto(66);
    check("sfx3_grant", enable_sfx, 4'b1000);
    goto(67);
    check("sfx3_audio", audio, 1'b1);
    game_state = 2'd3;
    goto(68);
    check("pause_sfx_abort", enable_sfx, 4'b0000);
    check("pause_busy", sfx_busy, 1'b0);
    check_bgm("pause_bgm", 3'b000);
    goto(69);
    check("pause_audio", audio, 1'b0);
    sfx_req = 4'b0101;
    goto(70);
    sfx_req = 4'b0000;
    goto(71);
    game_state = 2'd1;
    goto(72);
    check("unpause_no_grant_a", enable_sfx, 4'b0000);
    goto(75);
    check("unpause_no_grant_b", enable_sfx, 4'b0000);
    goto(79);
    check_bgm("unpause_gap", 3'b000);
    goto(80);
    check_bgm("unpause_play", 3'b010);
    check("unpause_no_grant_c", enable_sfx, 4'b0000);
    check("unpause_busy", sfx_busy, 1'b0);

    // Reset mid-effect with another request pending
    sfx_req = 4'b0011;
    goto(81);
    sfx_req = 4'b0000;
    goto(82);
    check("pre_reset_grant", enable_sfx, 4'b0001);
    audio_sfx = 4'b1111;
    goto(83);
    check("pre_reset_audio", audio, 1'b1);
    rst        = 1'b1;
    game_state = 2'd0;
    goto(84);
    check_bgm("rst_bgm", 3'b000);
    check("rst_sfx", enable_sfx, 4'b0000);
    check("rst_busy", sfx_busy, 1'b0);
    check("rst_audio", audio, 1'b0);
    rst  = 1'b0;
    base = cyc;   // new E0
    goto(2);
    check("rst_pending_cleared", enable_sfx, 4'b0000);
    goto(7);
    check_bgm("rst_gap", 3'b000);
    goto(8);
    check_bgm("rst_start_again", 3'b001);
    check("rst_no_grant", enable_sfx, 4'b0000);
    check("rst_no_busy", sfx_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
